// File: rtl/data_bus_arbiter_pkg.sv
// Shared definitions for the two-master data bus arbiter: FSM encodings,
// transfer size codes and the default ACCESS timeout.
package data_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/data_bus_arbiter_rr_pick.sv
// Two-way round-robin winner selection: on contention the requester that was
// not granted last wins, otherwise the sole requester wins.
module bus_rr_pick (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       any,
   output logic       winner
);

   always_comb begin
      any    = |req;
      winner = 1'b0;
      if (req == 2'b11) begin
         winner = ~last_grant;
      end else if (req[1]) begin
         winner = 1'b1;
      end
   end

endmodule

// File: rtl/data_bus_arbiter.sv
// Arbitrates a CPU port (m0) and a debug/DMA port (m1) onto one data bus
// controller, one transfer at a time, with a per-access ready timeout.
module data_bus_arbiter
   import data_bus_arbiter_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [1:0]  m0_size,
   input  logic [31:0] m0_wdata,
   output logic        m0_gnt,
   output logic        m0_ack,
   output logic        m0_err,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [1:0]  m1_size,
   input  logic [31:0] m1_wdata,
   output logic        m1_gnt,
   output logic        m1_ack,
   output logic        m1_err,
   output logic [31:0] m1_rdata,
   output logic        bus_rd,
   output logic        bus_wd,
   output logic [31:0] bus_addr_in,
   output logic [31:0] bus_addr_out,
   output logic [1:0]  bus_size_in,
   output logic [1:0]  bus_size_out,
   output logic [31:0] bus_data_in,
   input  logic [31:0] bus_data_out,
   input  logic        bus_ready,
   input  logic        bus_busy
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t      state_q;
   state_t      state_d;
   logic        owner_q;
   logic        last_grant_q;
   logic        we_q;
   logic        err_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic [1:0]  size_q;
   logic [CNT_W-1:0] count_q;
   logic        pick_any;
   logic        pick_winner;
   logic        strobe;
   logic        timeout_hit;

   bus_rr_pick u_pick (
      .req        ({m1_req, m0_req}),
      .last_grant (last_grant_q),
      .any        (pick_any),
      .winner     (pick_winner)
   );

   assign strobe      = (state_q == ACCESS) && bus_ready && !bus_busy;
   assign timeout_hit = (state_q == ACCESS) && !strobe && (count_q == CNT_W'(TIMEOUT - 1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pick_any) state_d = ACCESS;
         ACCESS:  if (strobe || timeout_hit) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // The transfer descriptor is captured once at grant so the bus sees stable
   // address/size/data for the whole access, regardless of what the master does.
   always_ff @(posedge clk) begin
      if (!rst) begin
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         we_q         <= 1'b0;
         err_q        <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         size_q       <= SIZE_BYTE;
         count_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_any) begin
                  owner_q      <= pick_winner;
                  last_grant_q <= pick_winner;
                  we_q         <= pick_winner ? m1_we    : m0_we;
                  addr_q       <= pick_winner ? m1_addr  : m0_addr;
                  size_q       <= pick_winner ? m1_size  : m0_size;
                  wdata_q      <= pick_winner ? m1_wdata : m0_wdata;
                  count_q      <= '0;
                  err_q        <= 1'b0;
               end
            end
            ACCESS: begin
               if (strobe) begin
                  err_q <= 1'b0;
                  if (!we_q) rdata_q <= bus_data_out;
               end else if (timeout_hit) begin
                  err_q   <= 1'b1;
                  rdata_q <= '0;
               end else begin
                  count_q <= count_q + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus_rd       = strobe && !we_q;
   assign bus_wd       = strobe && we_q;
   assign bus_addr_in  = addr_q;
   assign bus_addr_out = addr_q;
   assign bus_size_in  = size_q;
   assign bus_size_out = size_q;
   assign bus_data_in  = wdata_q;

   assign m0_gnt   = (state_q != IDLE) && !owner_q;
   assign m1_gnt   = (state_q != IDLE) && owner_q;
   assign m0_ack   = (state_q == RESP) && !owner_q;
   assign m1_ack   = (state_q == RESP) && owner_q;
   assign m0_err   = m0_ack && err_q;
   assign m1_err   = m1_ack && err_q;
   assign m0_rdata = rdata_q;
   assign m1_rdata = rdata_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Scoreboard bench: a transfer-level model predicts winner, completion cycle,
// err and rdata; a negedge monitor checks every strobe and ack against it.
module tb_data_bus_arbiter;
   import data_bus_arbiter_pkg::*;

   localparam int TIMEOUT = TIMEOUT_DEFAULT;

   logic        clk;
   logic        rst;
   logic        m0_req, m0_we, m0_gnt, m0_ack, m0_err;
   logic [31:0] m0_addr, m0_wdata, m0_rdata;
   logic [1:0]  m0_size;
   logic        m1_req, m1_we, m1_gnt, m1_ack, m1_err;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;
   logic [1:0]  m1_size;
   logic        bus_rd, bus_wd, bus_ready, bus_busy;
   logic [31:0] bus_addr_in, bus_addr_out, bus_data_in, bus_data_out;
   logic [1:0]  bus_size_in, bus_size_out;

   typedef struct {
      int          master;
      logic        we;
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
      int          ack_cyc;
      int          strobe_cyc;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          strobes_seen = 0;
   int          model_last = 1;
   bit          pend[2];
   logic        op_we[2];
   logic [31:0] op_addr[2];
   logic [1:0]  op_size[2];
   logic [31:0] op_wdata[2];

   data_bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_size(m0_size), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_size(m1_size), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .bus_rd(bus_rd), .bus_wd(bus_wd), .bus_addr_in(bus_addr_in), .bus_addr_out(bus_addr_out),
      .bus_size_in(bus_size_in), .bus_size_out(bus_size_out), .bus_data_in(bus_data_in),
      .bus_data_out(bus_data_out), .bus_ready(bus_ready), .bus_busy(bus_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: actual=0x%08h required=0x%08h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic drive_req(input int m, input logic v);
      if (m == 0) m0_req = v;
      else        m1_req = v;
   endtask

   task automatic apply_stimulus(input int m, input logic we, input logic [31:0] addr,
                                 input logic [1:0] size, input logic [31:0] wdata);
      pend[m] = 1'b1;
      op_we[m] = we; op_addr[m] = addr; op_size[m] = size; op_wdata[m] = wdata;
      if (m == 0) begin
         m0_we = we; m0_addr = addr; m0_size = size; m0_wdata = wdata;
      end else begin
         m1_we = we; m1_addr = addr; m1_size = size; m1_wdata = wdata;
      end
      drive_req(m, 1'b1);
   endtask

   task automatic apply_random(input int m);
      logic [1:0] sz;
      case ($urandom_range(0, 2))
         0:       sz = SIZE_BYTE;
         1:       sz = SIZE_HALF;
         default: sz = SIZE_WORD;
      endcase
      apply_stimulus(m, 1'($urandom_range(0, 1)), $urandom, sz, $urandom);
   endtask

   // One arbitration round starting in an IDLE cycle; first_avail >= TIMEOUT
   // means the controller never becomes available and the access times out.
   task automatic run_round(input int first_avail, input bit force_busy,
                            input bit fixed, input logic [31:0] fixed_data);
      exp_t        e;
      int          win;
      int          n;
      int          r;
      logic [31:0] data[TIMEOUT];
      win = (pend[0] && pend[1]) ? (model_last == 1 ? 0 : 1) : (pend[1] ? 1 : 0);
      model_last = win;
      for (int j = 0; j < TIMEOUT; j++) data[j] = $urandom;
      if (fixed && first_avail < TIMEOUT) data[first_avail] = fixed_data;
      e.master = win; e.we = op_we[win]; e.addr = op_addr[win];
      e.size = op_size[win]; e.wdata = op_wdata[win];
      e.err = (first_avail >= TIMEOUT);
      e.rdata = e.err ? 32'h0 : data[first_avail];
      e.ack_cyc = cyc + 2 + (e.err ? TIMEOUT - 1 : first_avail);
      e.strobe_cyc = cyc + 1 + first_avail;
      exp_q.push_back(e);
      n = e.err ? TIMEOUT : first_avail + 1;
      for (int j = 0; j < n; j++) begin
         @(posedge clk); #1;
         if (j == 0 && $urandom_range(0, 3) == 0) drive_req(win, 1'b0);
         bus_data_out = data[j];
         if (j == first_avail) begin
            bus_ready = 1'b1; bus_busy = 1'b0;
         end else if (force_busy) begin
            bus_ready = 1'b1; bus_busy = 1'b1;
         end else begin
            r = $urandom_range(0, 2);
            bus_ready = (r == 2);
            bus_busy  = (r != 0);
         end
      end
      @(posedge clk); #1;
      bus_ready = 1'($urandom_range(0, 1));
      bus_busy  = 1'($urandom_range(0, 1));
      bus_data_out = $urandom;
      drive_req(win, 1'b0);
      pend[win] = 1'b0;
      @(posedge clk); #1;
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst) begin
         check_output("single_gnt", {31'b0, m0_gnt & m1_gnt}, 32'd0);
         if (bus_rd || bus_wd) begin
            check_output("strobe_ready", {31'b0, bus_ready & ~bus_busy}, 32'd1);
            if (exp_q.size() == 0) begin
               check_output("strobe_unexpected", {31'b0, bus_rd | bus_wd}, 32'd0);
            end else begin
               mon_e = exp_q[0];
               check_output("strobe_kind", {30'b0, bus_rd, bus_wd}, {30'b0, ~mon_e.we, mon_e.we});
               check_output("strobe_cycle", cyc, mon_e.strobe_cyc);
               check_output("addr_in", bus_addr_in, mon_e.addr);
               check_output("addr_out", bus_addr_out, mon_e.addr);
               check_output("size_in", {30'b0, bus_size_in}, {30'b0, mon_e.size});
               check_output("size_out", {30'b0, bus_size_out}, {30'b0, mon_e.size});
               check_output("data_in", bus_data_in, mon_e.wdata);
               strobes_seen++;
            end
         end
         if (m0_ack || m1_ack) begin
            if (exp_q.size() == 0) begin
               check_output("ack_unexpected", {31'b0, m0_ack | m1_ack}, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check_output("dual_ack", {31'b0, m0_ack & m1_ack}, 32'd0);
               check_output("ack_master", {31'b0, m1_ack}, mon_e.master);
               check_output("ack_gnt", {31'b0, mon_e.master == 1 ? m1_gnt : m0_gnt}, 32'd1);
               check_output("ack_err", {31'b0, m1_ack ? m1_err : m0_err}, {31'b0, mon_e.err});
               if (!mon_e.we || mon_e.err)
                  check_output("ack_rdata", m1_ack ? m1_rdata : m0_rdata, mon_e.rdata);
               check_output("ack_cycle", cyc, mon_e.ack_cyc);
               check_output("strobe_count", strobes_seen, mon_e.err ? 0 : 1);
            end
            strobes_seen = 0;
         end
      end
   end

   initial begin
      #600000;
      $display("[TB] FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      m0_req = 0; m0_we = 0; m0_addr = 0; m0_size = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_addr = 0; m1_size = 0; m1_wdata = 0;
      bus_ready = 0; bus_busy = 0; bus_data_out = 0;
      pend[0] = 0; pend[1] = 0;
      apply_random(0);
      apply_random(1);
      repeat (2) @(posedge clk);
      #1;
      check_output("rst_ctrl", {24'b0, m0_gnt, m1_gnt, m0_ack, m1_ack, m0_err, m1_err, bus_rd, bus_wd}, 32'd0);
      check_output("rst_rdata", m0_rdata | m1_rdata, 32'd0);
      rst = 1'b1;

      $display("[TB] contention from reset");
      for (int i = 0; i < 4; i++) begin
         if (!pend[0]) apply_random(0);
         if (!pend[1]) apply_random(1);
         run_round($urandom_range(0, 2), 0, 0, 0);
      end
      while (pend[0] || pend[1]) run_round(0, 0, 0, 0);

      $display("[TB] directed read, busy write, timeout");
      apply_stimulus(0, 1'b0, 32'h100, SIZE_WORD, 32'h0);
      run_round(0, 0, 1, 32'hDEADBEEF);
      apply_stimulus(1, 1'b1, 32'h204, SIZE_BYTE, 32'h000000A5);
      run_round(3, 1, 0, 0);
      apply_stimulus(0, 1'b0, 32'h300, SIZE_WORD, 32'h0);
      run_round(TIMEOUT, 0, 0, 0);

      $display("[TB] randomized traffic");
      for (int r = 0; r < 40; r++) begin
         for (int m = 0; m < 2; m++)
            if (!pend[m] && $urandom_range(0, 1) == 1) apply_random(m);
         if (!pend[0] && !pend[1]) apply_random($urandom_range(0, 1));
         run_round(($urandom_range(0, 5) == 0) ? TIMEOUT : $urandom_range(0, 4),
                   1'($urandom_range(0, 1)), 0, 0);
      end
      while (pend[0] || pend[1]) run_round(0, 0, 0, 0);

      $display("[TB] reset during access");
      bus_ready = 1'b0; bus_busy = 1'b0;
      apply_stimulus(0, 1'b0, 32'h400, SIZE_WORD, 32'h0);
      @(posedge clk); #1;
      check_output("abort_gnt_before", {31'b0, m0_gnt}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      drive_req(0, 1'b0);
      pend[0] = 1'b0;
      @(posedge clk); #1;
      check_output("abort_ctrl", {24'b0, m0_gnt, m1_gnt, m0_ack, m1_ack, m0_err, m1_err, bus_rd, bus_wd}, 32'd0);
      check_output("abort_rdata", m0_rdata | m1_rdata, 32'd0);
      check_output("abort_bus", bus_addr_in | bus_addr_out | bus_data_in | {30'b0, bus_size_in | bus_size_out}, 32'd0);
      rst = 1'b1;
      model_last = 1;
      @(posedge clk); #1;
      check_output("abort_no_ack", {30'b0, m0_ack, m1_ack}, 32'd0);
      apply_stimulus(1, 1'b0, 32'h500, SIZE_HALF, 32'h0);
      run_round(1, 0, 1, 32'h12345678);

      repeat (3) @(negedge clk);
      check_output("queue_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
